// File: rtl/serial_rx_pkg.sv
// serial_rx_pkg: framing constants and state encoding shared by both ends of the link.
// The state type widens to 3 bits when SERIAL_RX_PARITY_CHECK_EN is defined.
package serial_rx_pkg;

  localparam int unsigned BIT_CYCLES_DEFAULT = 8;
  localparam logic        IDLE_LEVEL         = 1'b1;

`ifdef SERIAL_RX_PARITY_CHECK_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;
`endif

endpackage

// File: rtl/serial_rx_bit_timer.sv
// serial_rx_bit_timer: modulo-BIT_CYCLES counter with synchronous clear and
// mid-bit / end-of-bit ticks; the transmitter reuses it for its bit pacing.
module serial_rx_bit_timer
  import serial_rx_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = BIT_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic mid_tick_o,
  output logic end_tick_o
);

  logic [7:0] cnt_q, cnt_d;

  assign mid_tick_o = (cnt_q == 8'(BIT_CYCLES / 2 - 1));
  assign end_tick_o = (cnt_q == 8'(BIT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (clr_i || end_tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_rx.sv
// serial_rx: receives start / DATA_W data (LSB first) / [even parity] / stop frames.
// Define SERIAL_RX_PARITY_CHECK_EN to compile in the parity bit and its check.
//
// state    | meaning
// IDLE     | line idle, waiting for a low level
// START    | confirming the start bit at mid-bit
// DATA     | sampling data bits once per bit period
// PARITY   | sampling the parity bit (parity build only)
// STOP     | sampling the stop bit, then publish or reject
module serial_rx
  import serial_rx_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BIT_CYCLES = BIT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serin,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned      IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;
  logic                tmr_clr, mid_tick, end_tick;
  logic                parity_ok;

`ifdef SERIAL_RX_PARITY_CHECK_EN
  logic par_q, par_d;
  assign parity_ok = ~(^{shift_q, par_q});
`else
  assign parity_ok = 1'b1;
`endif

  serial_rx_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (tmr_clr),
    .mid_tick_o (mid_tick),
    .end_tick_o (end_tick)
  );

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    tmr_clr = 1'b0;
`ifdef SERIAL_RX_PARITY_CHECK_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Holding the timer at zero here means START begins timing from entry.
        tmr_clr = 1'b1;
        if (serin != IDLE_LEVEL) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (mid_tick) begin
          // Re-aligning the timer here puts every later end_tick at mid-bit.
          tmr_clr = 1'b1;
          if (serin == IDLE_LEVEL) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            idx_d   = '0;
          end
        end
      end
      ST_DATA: begin
        if (end_tick) begin
          shift_d[idx_q] = serin;
          if (idx_q == LAST_IDX) begin
`ifdef SERIAL_RX_PARITY_CHECK_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef SERIAL_RX_PARITY_CHECK_EN
      ST_PARITY: begin
        if (end_tick) begin
          par_d   = serin;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (end_tick) begin
          state_d = ST_IDLE;
          if ((serin == IDLE_LEVEL) && parity_ok) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_CHECK_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef SERIAL_RX_PARITY_CHECK_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: randomized and directed frames checked against a frame-level model.
module tb_serial_rx;

  localparam int DW = 8;
  localparam int BC = 8;
`ifdef SERIAL_RX_PARITY_CHECK_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int LAT   = (DW + 1) * BC + BC / 2 + PAR_EN * BC;
  localparam int FRAME = (DW + 2 + PAR_EN) * BC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          serin = 1'b1;
  logic [DW-1:0] data_out;
  logic          valid, frame_err, busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int both_hi = 0;
  int vq[$];
  int eq[$];
  logic [DW-1:0] dq[$];
  logic [DW-1:0] exp_data;

  serial_rx #(.DATA_W(DW), .BIT_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .serin(serin), .data_out(data_out),
    .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      vq.push_back(cyc);
      dq.push_back(data_out);
    end
    if (frame_err) eq.push_back(cyc);
    if (valid && frame_err) both_hi++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic clear_q();
    vq.delete(); eq.delete(); dq.delete();
  endtask

  task automatic idle(input int n);
    serin = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame starting just after a posedge; e0 is the edge that first sees the start bit.
  task automatic send_frame(input logic [DW-1:0] d, input logic bad_par, input logic stop,
                            output int e0);
    e0 = cyc + 1;
    serin = 1'b0;
    repeat (BC) @(posedge clk);
    #1;
    for (int i = 0; i < DW; i++) begin
      serin = d[i];
      repeat (BC) @(posedge clk);
      #1;
    end
    if (PAR_EN != 0) begin
      serin = (^d) ^ bad_par;
      repeat (BC) @(posedge clk);
      #1;
    end
    serin = stop;
    repeat (BC) @(posedge clk);
    #1;
  endtask

  function automatic logic frame_good(input logic stop, input logic bad_par);
    return stop && ((PAR_EN == 0) || !bad_par);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    serin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (data_out !== '0) begin fails++; $display("FAIL reset_data: got %0h exp 0", data_out); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b exp 0", valid); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %0b exp 0", frame_err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b exp 0", busy); end
    rst = 1'b0;
    idle(4);
    exp_data = '0;
    clear_q();
  endtask

  task automatic test_good_frame();
    int e0;
    send_frame(8'hA5, 1'b0, 1'b1, e0);
    idle(12);
    tests++; if (vq.size() != 1) begin fails++; $display("FAIL good_valid_cnt: got %0d exp 1", vq.size()); end
    else begin
      tests++; if (vq[0] - e0 != LAT) begin fails++; $display("FAIL good_latency: got %0d exp %0d", vq[0] - e0, LAT); end
    end
    tests++; if (eq.size() != 0) begin fails++; $display("FAIL good_ferr_cnt: got %0d exp 0", eq.size()); end
    tests++; if (data_out !== 8'hA5) begin fails++; $display("FAIL good_data: got %0h exp a5", data_out); end
    exp_data = 8'hA5;
    clear_q();
  endtask

  task automatic test_bad_stop();
    int e0;
    send_frame(8'h3C, 1'b0, 1'b0, e0);
    idle(12);
    tests++; if (eq.size() != 1) begin fails++; $display("FAIL badstop_ferr_cnt: got %0d exp 1", eq.size()); end
    else begin
      tests++; if (eq[0] - e0 != LAT) begin fails++; $display("FAIL badstop_latency: got %0d exp %0d", eq[0] - e0, LAT); end
    end
    tests++; if (vq.size() != 0) begin fails++; $display("FAIL badstop_valid_cnt: got %0d exp 0", vq.size()); end
    tests++; if (data_out !== exp_data) begin fails++; $display("FAIL badstop_data: got %0h exp %0h", data_out, exp_data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL badstop_idle: got busy %0b exp 0", busy); end
    clear_q();
  endtask

  task automatic test_start_glitch();
    serin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    serin = 1'b1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_hi: got %0b exp 1", busy); end
    repeat (3) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_lo: got %0b exp 0", busy); end
    idle(FRAME);
    tests++; if (vq.size() + eq.size() != 0) begin fails++; $display("FAIL glitch_pulses: got %0d exp 0", vq.size() + eq.size()); end
    clear_q();
  endtask

  task automatic test_back_to_back();
    int e0a, e0b;
    send_frame(8'h01, 1'b0, 1'b1, e0a);
    send_frame(8'hFF, 1'b0, 1'b1, e0b);
    idle(12);
    tests++; if (vq.size() != 2) begin fails++; $display("FAIL b2b_valid_cnt: got %0d exp 2", vq.size()); end
    else begin
      tests++; if (vq[1] - vq[0] != FRAME) begin fails++; $display("FAIL b2b_spacing: got %0d exp %0d", vq[1] - vq[0], FRAME); end
      tests++; if (dq[0] !== 8'h01) begin fails++; $display("FAIL b2b_first: got %0h exp 01", dq[0]); end
      tests++; if (dq[1] !== 8'hFF) begin fails++; $display("FAIL b2b_second: got %0h exp ff", dq[1]); end
    end
    tests++; if (eq.size() != 0) begin fails++; $display("FAIL b2b_ferr_cnt: got %0d exp 0", eq.size()); end
    exp_data = 8'hFF;
    clear_q();
  endtask

  task automatic test_reset_mid();
    int e0;
    logic [DW-1:0] d;
    d = 8'h55;
    serin = 1'b0;
    repeat (BC) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      serin = d[i];
      repeat ((i == 3) ? BC / 2 : BC) @(posedge clk);
      #1;
    end
    rst = 1'b1;
    serin = 1'b1;
    @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %0b exp 0", busy); end
    tests++; if (data_out !== '0) begin fails++; $display("FAIL rstmid_data: got %0h exp 0", data_out); end
    rst = 1'b0;
    idle(FRAME);
    tests++; if (vq.size() + eq.size() != 0) begin fails++; $display("FAIL rstmid_pulses: got %0d exp 0", vq.size() + eq.size()); end
    exp_data = '0;
    clear_q();
    send_frame(8'h12, 1'b0, 1'b1, e0);
    idle(12);
    tests++; if (vq.size() != 1 || data_out !== 8'h12) begin
      fails++; $display("FAIL rstmid_next: got cnt %0d data %0h exp cnt 1 data 12", vq.size(), data_out);
    end
    exp_data = 8'h12;
    clear_q();
  endtask

  task automatic test_parity();
    int e0;
    if (PAR_EN != 0) begin
      send_frame(8'h07, 1'b0, 1'b1, e0);
      idle(12);
      tests++; if (vq.size() != 1 || data_out !== 8'h07) begin
        fails++; $display("FAIL par_good: got cnt %0d data %0h exp cnt 1 data 07", vq.size(), data_out);
      end
      exp_data = 8'h07;
      clear_q();
      send_frame(8'h07, 1'b1, 1'b1, e0);
      idle(12);
      tests++; if (eq.size() != 1 || vq.size() != 0) begin
        fails++; $display("FAIL par_bad: got ferr %0d valid %0d exp ferr 1 valid 0", eq.size(), vq.size());
      end
      tests++; if (data_out !== exp_data) begin fails++; $display("FAIL par_bad_data: got %0h exp %0h", data_out, exp_data); end
      clear_q();
    end
  endtask

  task automatic test_random();
    int e0;
    logic [DW-1:0] d;
    logic stop, bad_par, good;
    for (int n = 0; n < 16; n++) begin
      d       = DW'($urandom_range(0, 255));
      stop    = ($urandom_range(0, 3) != 0);
      bad_par = ($urandom_range(0, 3) == 0);
      good    = frame_good(stop, bad_par);
      send_frame(d, bad_par, stop, e0);
      idle(12);
      if (good) begin
        exp_data = d;
        tests++; if (vq.size() != 1 || eq.size() != 0) begin
          fails++; $display("FAIL rand_good_pulses[%0d]: got valid %0d ferr %0d exp 1/0", n, vq.size(), eq.size());
        end else begin
          tests++; if (vq[0] - e0 != LAT) begin fails++; $display("FAIL rand_latency[%0d]: got %0d exp %0d", n, vq[0] - e0, LAT); end
        end
      end else begin
        tests++; if (eq.size() != 1 || vq.size() != 0) begin
          fails++; $display("FAIL rand_bad_pulses[%0d]: got valid %0d ferr %0d exp 0/1", n, vq.size(), eq.size());
        end
      end
      tests++; if (data_out !== exp_data) begin fails++; $display("FAIL rand_data[%0d]: got %0h exp %0h", n, data_out, exp_data); end
      clear_q();
    end
  endtask

  // Line stuck low: released right after the third rejected frame so nothing else starts.
  task automatic test_stuck_low();
    serin = 1'b0;
    repeat (3 * LAT + 3) @(posedge clk);
    #1;
    serin = 1'b1;
    idle(FRAME);
    tests++; if (eq.size() != 3) begin fails++; $display("FAIL stuck_ferr_cnt: got %0d exp 3", eq.size()); end
    tests++; if (vq.size() != 0) begin fails++; $display("FAIL stuck_valid_cnt: got %0d exp 0", vq.size()); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL stuck_busy: got %0b exp 0", busy); end
    tests++; if (data_out !== exp_data) begin fails++; $display("FAIL stuck_data: got %0h exp %0h", data_out, exp_data); end
    clear_q();
  endtask

  initial begin
    exp_data = '0;
    test_reset();
    test_good_frame();
    test_bad_stop();
    test_start_glitch();
    test_back_to_back();
    test_reset_mid();
    test_parity();
    test_random();
    test_stuck_low();
    tests++; if (both_hi != 0) begin fails++; $display("FAIL valid_and_ferr_together: got %0d exp 0", both_hi); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
